// File: rtl/jt10_adpcm_acc_pkg.sv
// Shared constants and arithmetic helpers for the ADPCM-A channel mixer.
// Width of the frame accumulator and of the final PCM sample live here.
package jt10_adpcm_acc_pkg;

    localparam int NCH   = 6;
    localparam int ACC_W = 18;
    localparam int PCM_W = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

    function automatic logic [PCM_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return 16'h7FFF;
        else if (v < SAT_MIN)
            return 16'h8000;
        else
            return v[PCM_W-1:0];
    endfunction

    // Clamp at the 18-bit rails instead of wrapping, so a frame that
    // overshoots the accumulator still saturates the output in the right direction.
    function automatic logic signed [ACC_W-1:0] add_clamp(input logic signed [ACC_W-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/jt10_adpcm_sat.sv
// Combinational 18-to-16 bit saturator for the mixed frame sum.
module jt10_adpcm_sat
    import jt10_adpcm_acc_pkg::*;
(
    input  logic signed [ACC_W-1:0] val_i,
    output logic        [PCM_W-1:0] sat_o
);

    assign sat_o = sat16(val_i);

endmodule

// File: rtl/jt10_adpcm_acc.sv
// Six-channel ADPCM-A mixer: sums one sample per channel slot, commits the
// frame total on the last slot and emits it saturated at the output rate.
module jt10_adpcm_acc
    import jt10_adpcm_acc_pkg::*;
(
    input  logic                     rst_n,
    input  logic                     clk,
    input  logic                     cen111,
    input  logic                     cen55,
    input  logic [2:0]               ch,
    input  logic signed [PCM_W-1:0]  pcm_in,
    output logic signed [PCM_W-1:0]  pcm_out
);

    localparam logic [2:0] LAST_CH = 3'(NCH - 1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] total_q, total_d;
    logic        [PCM_W-1:0] pcm_out_q, pcm_out_d;
    logic signed [ACC_W-1:0] pcm_ext;
    logic signed [ACC_W-1:0] sum;
    logic        [PCM_W-1:0] total_sat;

    assign pcm_ext = {{(ACC_W-PCM_W){pcm_in[PCM_W-1]}}, pcm_in};
    assign sum     = add_clamp(acc_q, pcm_ext);

    jt10_adpcm_sat u_sat (
        .val_i (total_q),
        .sat_o (total_sat)
    );

    always_comb begin
        acc_d     = acc_q;
        total_d   = total_q;
        pcm_out_d = pcm_out_q;
        // Slots 6 and 7 fall through untouched: they are not channels.
        if (cen111) begin
            if (ch == 3'd0) begin
                acc_d = pcm_ext;
            end else if (ch <= LAST_CH) begin
                acc_d = sum;
                if (ch == LAST_CH)
                    total_d = sum;
            end
        end
        if (cen55)
            pcm_out_d = total_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            total_q   <= '0;
            pcm_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            total_q   <= total_d;
            pcm_out_q <= pcm_out_d;
        end
    end

    assign pcm_out = pcm_out_q;

endmodule

// File: tb/tb_jt10_adpcm_acc.sv
// Bench for the six-channel ADPCM-A mixer: drives whole frames, predicts the
// saturated frame sum into a queue and compares once the output has settled.
module tb_jt10_adpcm_acc;

    logic               rst_n;
    logic               clk;
    logic               cen111;
    logic               cen55;
    logic [2:0]         ch;
    logic signed [15:0] pcm_in;
    logic signed [15:0] pcm_out;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_errors;
    logic        phase;

    jt10_adpcm_acc dut (
        .rst_n   (rst_n),
        .clk     (clk),
        .cen111  (cen111),
        .cen55   (cen55),
        .ch      (ch),
        .pcm_in  (pcm_in),
        .pcm_out (pcm_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_sat(input int s);
        logic [31:0] w;
        w = 32'(s);
        if (s > 32767)
            return 16'h7FFF;
        else if (s < -32768)
            return 16'h8000;
        else
            return w[15:0];
    endfunction

    // driver: one clk per call, cen55 alternates every cycle
    task automatic drive(input logic c111, input logic [2:0] c, input logic signed [15:0] d);
        cen111 = c111;
        ch     = c;
        pcm_in = d;
        cen55  = phase;
        phase  = ~phase;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
    endtask

    // hold_mask marks slots presented with cen111=0 (never slot 0);
    // bad inserts ch=6/7 slots inside and after the frame.
    task automatic run_frame(input string tag, input int s[6], input logic [5:0] hold_mask,
                             input bit bad);
        int          sum;
        logic [15:0] exp;
        sum   = 0;
        phase = 1'($urandom_range(0, 1));
        for (int i = 0; i < 6; i++) begin
            if (bad && i == 3) begin
                drive(1'b1, 3'd6, 16'sd5000);
                drive(1'b1, 3'd7, 16'sd5000);
            end
            if (hold_mask[i]) begin
                drive(1'b0, 3'(i), 16'sd7777);
            end else begin
                drive(1'b1, 3'(i), 16'(s[i]));
                sum += s[i];
            end
        end
        if (bad) begin
            drive(1'b1, 3'd6, 16'sd5000);
            drive(1'b1, 3'd7, -16'sd5000);
        end
        exp_q.push_back(exp_sat(sum));
        idle();
        idle();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, pcm_out, exp);
            idle();
            idle();
            idle();
            check({tag, "_hold"}, pcm_out, exp);
        end
    endtask

    initial begin
        int s[6];
        n_checks = 0;
        n_errors = 0;
        phase    = 1'b0;
        rst_n    = 1'b0;
        cen111   = 1'b1;
        cen55    = 1'b1;
        ch       = 3'd5;
        pcm_in   = 16'sd12345;

        // reset with live inputs
        repeat (3) begin
            @(posedge clk);
            pcm_in = 16'($urandom_range(0, 65535));
            ch     = 3'($urandom_range(0, 7));
            #1;
            check("reset_out", pcm_out, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        check("reset_total", pcm_out, 16'h0000);

        s = '{100, 100, 100, 100, 100, 100};
        run_frame("sum600", s, 6'b0, 1'b0);

        s = '{-32768, -32768, -32768, -32768, -32768, -32768};
        run_frame("neg_sat", s, 6'b0, 1'b0);

        s = '{20000, 20000, 20000, 20000, 20000, 20000};
        run_frame("pos_sat", s, 6'b0, 1'b0);

        s = '{0, 0, 0, 0, 0, 0};
        run_frame("zeros", s, 6'b0, 1'b0);

        s = '{1000, 0, 0, 0, 0, -300};
        run_frame("held_ch3", s, 6'b001000, 1'b0);

        s = '{1234, -567, 89, 4000, -2500, 31};
        run_frame("bad_ch", s, 6'b0, 1'b1);

        s = '{32767, 0, 0, 0, 0, 0};
        run_frame("edge_max", s, 6'b0, 1'b0);

        s = '{16384, 16384, 0, 0, 0, 0};
        run_frame("edge_over", s, 6'b0, 1'b0);

        s = '{-32768, 0, 0, 0, 0, 0};
        run_frame("edge_min", s, 6'b0, 1'b0);

        s = '{-16384, -16384, 0, 0, 0, -1};
        run_frame("edge_under", s, 6'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 6; i++)
                s[i] = $urandom_range(0, 40000) - 20000;
            run_frame("random", s, 6'b0, 1'(k % 2));
        end

        // 128-sample sine on ch0 and a phase-shifted copy on ch5
        for (int k = 0; k < 128; k++) begin
            s    = '{0, 0, 0, 0, 0, 0};
            s[0] = $rtoi(12000.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
            s[5] = $rtoi(12000.0 * $sin(2.0 * 3.14159265358979 * ((k + 32) % 128) / 128.0));
            run_frame("sine", s, 6'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
